jtaguart_bridge: RTL and testbench

Parametrised Avalon-MM master that drives the `jtag_uart` core's slave port, replacing the single-character writer. A TX byte stream enters through a valid/ready port and is buffered in a TX FIFO. The bridge tracks write space in the core using credits read from the control register, so no character is ever dropped by the core. An optional RX path polls the data register and presents received bytes on a valid/ready port.

---
 rtl/jtaguart_bridge.sv | 230 +++++++++++++++++++++++
 tb/tb_jtaguart_bridge.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtaguart_bridge.sv
// jtaguart_bridge: Avalon-MM master for the jtag_uart slave port.
// It buffers an outgoing byte stream in a TX FIFO and writes the bytes to the
// core's data register. Writes are gated by credits read from the control
// register, so the core never drops a character.
// Optional RX path, built only when JTAGUART_RX_EN is defined: the bridge
// polls the data register and presents each received byte on a valid/ready port.
// Without the macro the RX ports remain present, but they are tied off and
// rx_ready is ignored.
module jtaguart_bridge #(
  parameter int TX_DEPTH      = 16,
  parameter int POLL_INTERVAL = 1024,
  parameter int CREDIT_MAX    = 64
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [7:0]                  tx_data,
  input  logic                        tx_valid,
  output logic                        tx_ready,
  output logic [$clog2(TX_DEPTH):0]   tx_level,
  output logic [7:0]                  rx_data,
  output logic                        rx_valid,
  input  logic                        rx_ready,
  output logic                        av_chipselect,
  output logic                        av_address,
  output logic                        av_read_n,
  output logic                        av_write_n,
  output logic [31:0]                 av_writedata,
  input  logic [31:0]                 av_readdata,
  input  logic                        av_waitrequest
);

  localparam int AW = $clog2(TX_DEPTH);
  localparam int TW = $clog2(POLL_INTERVAL);
  localparam logic [AW:0]   DepthW      = (AW+1)'(TX_DEPTH);
  localparam logic [TW-1:0] TimerReload = TW'(POLL_INTERVAL - 1);
  localparam logic [15:0]   CreditMaxW  = 16'(CREDIT_MAX);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_CTRL = 2'd1,
    WR_DATA = 2'd2,
    RD_DATA = 2'd3
  } state_e;

  state_e state_q, state_d;

  // TX FIFO storage and bookkeeping
  logic [7:0]    mem_q [TX_DEPTH];
  logic [AW-1:0] wrPtr_q, rdPtr_q;
  logic [AW:0]   level_q;
  logic          full, empty, push, pop;

  // Credit, poll timer and control-read permission
  logic [15:0]   credit_q, credit_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          ctrlOk_q, ctrlOk_d;
  logic [15:0]   wspace;
  logic          ctrlDone;

  // Registered Avalon command outputs
  logic          csel_q, csel_d;
  logic          addr_q, addr_d;
  logic          readN_q, readN_d;
  logic          writeN_q, writeN_d;
  logic [31:0]   wdata_q, wdata_d;

  // RX-side view shared by both build variants
  logic          rxDue, rxDone, rxValidInt;
  logic          unusedBits;

  assign full     = (level_q == DepthW);
  assign empty    = (level_q == '0);
  assign tx_ready = !full;
  assign push     = tx_valid && !full;
  assign pop      = (state_q == WR_DATA) && !av_waitrequest;
  assign tx_level = level_q;

  assign wspace   = av_readdata[31:16];
  assign ctrlDone = (state_q == RD_CTRL) && !av_waitrequest;

  assign av_chipselect = csel_q;
  assign av_address    = addr_q;
  assign av_read_n     = readN_q;
  assign av_write_n    = writeN_q;
  assign av_writedata  = wdata_q;

`ifdef JTAGUART_RX_EN
  logic [7:0] rxData_q;
  logic       rxValid_q;
  logic       rxMore_q;

  assign rxDone     = (state_q == RD_DATA) && !av_waitrequest;
  assign rxDue      = (timer_q == '0) || rxMore_q;
  assign rxValidInt = rxValid_q;
  assign rx_data    = rxData_q;
  assign rx_valid   = rxValid_q;
  assign unusedBits = ^av_readdata[14:8];

  // Capture a received byte from a data read and hold it until the consumer takes it
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rxData_q  <= 8'h00;
      rxValid_q <= 1'b0;
      rxMore_q  <= 1'b0;
    end else begin
      if (rxDone) begin
        if (av_readdata[15]) begin
          rxData_q  <= av_readdata[7:0];
          rxValid_q <= 1'b1;
        end
        rxMore_q <= (av_readdata[31:16] != 16'h0000);
      end else if (rxValid_q && rx_ready) begin
        rxValid_q <= 1'b0;
      end
    end
  end
`else
  assign rxDone     = 1'b0;
  assign rxDue      = 1'b0;
  assign rxValidInt = 1'b0;
  assign rx_data    = 8'h00;
  assign rx_valid   = 1'b0;
  assign unusedBits = ^{rx_ready, av_readdata[15:0]};
`endif

  // FIFO data array; contents need no reset because the pointers define validity
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wrPtr_q] <= tx_data;
    end
  end

  // FIFO pointers and occupancy; a push and a pop in the same cycle cancel out
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      level_q <= '0;
    end else begin
      if (push) begin
        wrPtr_q <= wrPtr_q + 1'b1;
      end
      if (pop) begin
        rdPtr_q <= rdPtr_q + 1'b1;
      end
      if (push && !pop) begin
        level_q <= level_q + 1'b1;
      end else if (pop && !push) begin
        level_q <= level_q - 1'b1;
      end
    end
  end

  // Bus arbitration in IDLE; a started transaction runs until the slave stops stalling
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (rxDue && !rxValidInt) begin
          state_d = RD_DATA;
        end else if (!empty && (credit_q != 16'h0000)) begin
          state_d = WR_DATA;
        end else if (!empty && (ctrlOk_q || (timer_q == '0))) begin
          state_d = RD_CTRL;
        end
      end
      RD_CTRL, WR_DATA, RD_DATA: begin
        if (!av_waitrequest) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Command outputs derived from the next state, so they are valid in the state's first cycle
  always_comb begin
    csel_d   = (state_d != IDLE);
    addr_d   = (state_d == RD_CTRL);
    readN_d  = !((state_d == RD_CTRL) || (state_d == RD_DATA));
    writeN_d = (state_d != WR_DATA);
    wdata_d  = wdata_q;
    if ((state_q == IDLE) && (state_d == WR_DATA)) begin
      wdata_d = {24'h000000, mem_q[rdPtr_q]};
    end
  end

  // Credit accounting, control-read permission and the saturating poll timer
  always_comb begin
    credit_d = credit_q;
    ctrlOk_d = ctrlOk_q;
    timer_d  = (timer_q != '0) ? (timer_q - 1'b1) : timer_q;
    if (ctrlDone) begin
      timer_d  = TimerReload;
      credit_d = (wspace > CreditMaxW) ? CreditMaxW : wspace;
      ctrlOk_d = (wspace != 16'h0000);
    end else if (pop) begin
      credit_d = credit_q - 1'b1;
    end
    if (rxDone) begin
      timer_d = TimerReload;
    end
  end

  // State, credit, timer and registered bus outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      credit_q <= 16'h0000;
      ctrlOk_q <= 1'b1;
      timer_q  <= TimerReload;
      csel_q   <= 1'b0;
      addr_q   <= 1'b0;
      readN_q  <= 1'b1;
      writeN_q <= 1'b1;
      wdata_q  <= 32'h0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      ctrlOk_q <= ctrlOk_d;
      timer_q  <= timer_d;
      csel_q   <= csel_d;
      addr_q   <= addr_d;
      readN_q  <= readN_d;
      writeN_q <= writeN_d;
      wdata_q  <= wdata_d;
    end
  end

endmodule

// File: tb/tb_jtaguart_bridge.sv
// Testbench for jtaguart_bridge: a behavioural jtag_uart slave with
// programmable stall, scoreboards for TX bytes and RX bytes.
// RX checks are built only when JTAGUART_RX_EN is defined.
module tb_jtaguart_bridge;

  localparam int TX_DEPTH      = 8;
  localparam int POLL_INTERVAL = 32;
  localparam int CREDIT_MAX    = 64;

  logic        clk;
  logic        reset_n;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [3:0]  tx_level;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        av_chipselect;
  logic        av_address;
  logic        av_read_n;
  logic        av_write_n;
  logic [31:0] av_writedata;
  logic [31:0] av_readdata;
  logic        av_waitrequest;

  int compareCount  = 0;
  int mismatchCount = 0;
  int cycle         = 0;

  logic [7:0]  sbQ[$];
  logic [7:0]  rxExp[$];
  logic [31:0] rxResp[$];

  int          waitCycles = 0;
  logic [15:0] slaveSpace = 16'd64;
  int          ctrlReads  = 0;
  int          dataReads  = 0;
  int          writes     = 0;
  int          lastCtrlAccept = 0;
  logic        haveCtrlAccept = 1'b0;
  int          lastGap    = -1;
  logic        sawFull    = 1'b0;

  jtaguart_bridge #(
    .TX_DEPTH(TX_DEPTH),
    .POLL_INTERVAL(POLL_INTERVAL),
    .CREDIT_MAX(CREDIT_MAX)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .tx_level(tx_level),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .rx_ready(rx_ready),
    .av_chipselect(av_chipselect),
    .av_address(av_address),
    .av_read_n(av_read_n),
    .av_write_n(av_write_n),
    .av_writedata(av_writedata),
    .av_readdata(av_readdata),
    .av_waitrequest(av_waitrequest)
  );

  // Free-running clock, 10 time units per cycle
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cycle counter used for measuring gaps between control reads
  initial begin
    forever begin
      @(posedge clk);
      cycle++;
    end
  end

  // Safety net so the run can never hang
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time exhausted, expected completion");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    tx_data  = b;
    tx_valid = 1'b1;
    while (!tx_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    checkOutput("pushAccepted", tx_ready, 1);
    if (tx_ready) sbQ.push_back(b);
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
  endtask

  task automatic waitDrain(input string tag, input int bound);
    int n = 0;
    while (!(tx_level == 0 && sbQ.size() == 0) && n < bound) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput(tag, (tx_level == 0 && sbQ.size() == 0), 1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic waitCtrlReads(input string tag, input int target, input int bound);
    int n = 0;
    while (ctrlReads < target && n < bound) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput(tag, ctrlReads, target);
  endtask

  // Behavioural jtag_uart slave: stalls each access, answers reads, scores writes
  initial begin
    int   waitCnt;
    logic prevValid;
    logic prevWait;
    logic [63:0] prevCmd;
    waitCnt = 0;
    prevValid = 1'b0;
    prevWait = 1'b0;
    prevCmd = '0;
    av_waitrequest = 1'b0;
    av_readdata = 32'h0;
    forever begin
      @(negedge clk);
      if (!reset_n || !av_chipselect) begin
        waitCnt = 0;
        av_waitrequest = 1'b0;
        av_readdata = 32'h0;
        prevValid = 1'b0;
      end else begin
        if (prevValid && prevWait)
          checkOutput("cmdStable", {av_address, av_read_n, av_write_n, av_writedata}, prevCmd);
        if (waitCnt == 0) begin
          if (!av_read_n && av_address && haveCtrlAccept)
            lastGap = cycle - lastCtrlAccept - 1;
          if (!av_read_n && !av_address)
            checkOutput("noRdWhileValid", rx_valid, 0);
        end
        av_waitrequest = (waitCnt < waitCycles);
        waitCnt++;
        if (av_address) av_readdata = {slaveSpace, 16'h0000};
        else            av_readdata = (rxResp.size() != 0) ? rxResp[0] : 32'h0;
        if (!av_waitrequest) begin
          if (!av_write_n) begin
            writes++;
            checkOutput("wrAddr", av_address, 0);
            checkOutput("sbNonEmpty", (sbQ.size() != 0), 1);
            if (sbQ.size() != 0) checkOutput("wrData", av_writedata, {24'h0, sbQ.pop_front()});
          end else if (av_address) begin
            ctrlReads++;
            lastCtrlAccept = cycle;
            haveCtrlAccept = 1'b1;
          end else begin
            dataReads++;
            if (rxResp.size() != 0) void'(rxResp.pop_front());
          end
        end
        prevValid = 1'b1;
        prevWait  = av_waitrequest;
        prevCmd   = {av_address, av_read_n, av_write_n, av_writedata};
      end
    end
  end

  // Watch the FIFO fill level: at full, tx_ready must be low
  initial begin
    forever begin
      @(negedge clk);
      if (reset_n && tx_level == TX_DEPTH) begin
        sawFull = 1'b1;
        checkOutput("readyAtFull", tx_ready, 0);
      end
    end
  end

  // Main test sequence
  initial begin
    int base;
    tx_data  = 8'h00;
    tx_valid = 1'b0;
    rx_ready = 1'b0;
    reset_n  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rstCs",     av_chipselect, 0);
    checkOutput("rstReadN",  av_read_n, 1);
    checkOutput("rstWriteN", av_write_n, 1);
    checkOutput("rstAddr",   av_address, 0);
    checkOutput("rstWdata",  av_writedata, 0);
    checkOutput("rstRxValid", rx_valid, 0);
    checkOutput("rstRxData", rx_data, 0);
    checkOutput("rstLevel",  tx_level, 0);
    checkOutput("rstReady",  tx_ready, 1);
    @(negedge clk);
    reset_n = 1'b1;

    $display("[TB] single byte with WSPACE=64");
    slaveSpace = 16'd64;
    applyStimulus(8'h41);
    repeat (10) @(posedge clk);
    #1;
    checkOutput("t1CtrlReads", ctrlReads, 1);
    checkOutput("t1Writes", writes, 1);

    $display("[TB] remaining 63 credits used without another control read");
    for (int i = 0; i < 63; i++) applyStimulus(8'(i + 8'h50));
    waitDrain("t1Drain", 400);
    checkOutput("t1NoReread", ctrlReads, 1);
    checkOutput("t1Writes64", writes, 64);

`ifndef JTAGUART_RX_EN
    $display("[TB] zero WSPACE: no writes, re-read after poll interval");
    slaveSpace = 16'd0;
    applyStimulus(8'hA0);
    applyStimulus(8'hA1);
    applyStimulus(8'hA2);
    waitCtrlReads("t2FirstZeroRead", 2, 50);
    waitCtrlReads("t2Reread", 3, POLL_INTERVAL + 40);
    checkOutput("t2Gap", lastGap, POLL_INTERVAL);
    checkOutput("t2NoWrites", writes, 64);
    checkOutput("t2Level", tx_level, 3);
    slaveSpace = 16'd200;
    waitCtrlReads("t2CreditRead", 4, POLL_INTERVAL + 40);
    checkOutput("t2Gap2", lastGap, POLL_INTERVAL);
    waitDrain("t2Drain", 100);
    checkOutput("t2Writes", writes, 67);
`else
    slaveSpace = 16'd200;
    applyStimulus(8'hA0);
    applyStimulus(8'hA1);
    applyStimulus(8'hA2);
    waitDrain("t2Drain", 200);
    checkOutput("t2CtrlReads", ctrlReads, 2);
    checkOutput("t2Writes", writes, 67);
`endif

    $display("[TB] WSPACE=200 saturates at CREDIT_MAX");
    base = ctrlReads;
    for (int i = 0; i < 61; i++) applyStimulus(8'(i + 8'h10));
    waitDrain("satDrain", 400);
    checkOutput("satNoReread", ctrlReads, base);
    applyStimulus(8'h7E);
    waitDrain("satDrain2", 100);
    checkOutput("satReread", ctrlReads, base + 1);
    checkOutput("satWrites", writes, 129);

    $display("[TB] FIFO fill with 5-cycle stalls");
    waitCycles = 5;
    for (int i = 0; i < 2 * TX_DEPTH; i++) applyStimulus(8'(8'hC0 + i));
    waitDrain("stallDrain", 600);
    checkOutput("stallSawFull", sawFull, 1);
    checkOutput("stallLevel", tx_level, 0);
    checkOutput("stallWrites", writes, 129 + 2 * TX_DEPTH);
    waitCycles = 0;

`ifdef JTAGUART_RX_EN
    $display("[TB] RX bytes with slow consumer");
    rxResp.push_back(32'h00028031);
    rxResp.push_back(32'h00018032);
    rxResp.push_back(32'h00008033);
    rxExp.push_back(8'h31);
    rxExp.push_back(8'h32);
    rxExp.push_back(8'h33);
    for (int i = 0; i < 3; i++) begin
      int n = 0;
      while (!rx_valid && n < 200) begin
        @(posedge clk);
        #1;
        n++;
      end
      checkOutput("rxArrived", rx_valid, 1);
      repeat (10) @(posedge clk);
      #1;
      checkOutput("rxHeld", rx_valid, 1);
      @(negedge clk);
      rx_ready = 1'b1;
      checkOutput("rxData", rx_data, rxExp.pop_front());
      @(posedge clk);
      #1;
      rx_ready = 1'b0;
      checkOutput("rxCleared", rx_valid, 0);
    end
    repeat (5) @(posedge clk);
    checkOutput("rxRespUsed", rxResp.size(), 0);
`endif

    $display("[TB] reset during a stalled write");
    waitCycles = 20;
    applyStimulus(8'h11);
    applyStimulus(8'h22);
    applyStimulus(8'h33);
    begin
      int n = 0;
      while (av_write_n && n < 100) begin
        @(posedge clk);
        #1;
        n++;
      end
      checkOutput("rstMidWriteSeen", av_write_n, 0);
    end
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("rstMidWriteN", av_write_n, 1);
    checkOutput("rstMidCs", av_chipselect, 0);
    checkOutput("rstMidReadN", av_read_n, 1);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    sbQ.delete();
    waitCycles = 0;
    @(posedge clk);
    #1;
    checkOutput("rstMidLevel", tx_level, 0);
    checkOutput("rstMidReady", tx_ready, 1);

`ifndef JTAGUART_RX_EN
    $display("[TB] idle with empty FIFO: no bus activity");
    begin
      int busCycles = 0;
      int rxSeen = 0;
      for (int i = 0; i < 3 * POLL_INTERVAL; i++) begin
        @(posedge clk);
        #1;
        if (av_chipselect || !av_read_n || !av_write_n) busCycles++;
        if (rx_valid) rxSeen++;
      end
      checkOutput("idleBus", busCycles, 0);
      checkOutput("idleRxValid", rxSeen, 0);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
